// File: rtl/turtle_mem_pkg.sv
// Shared types for the store path: store sizes, queue entry layout and queue FSM states.
package turtle_mem_pkg;

  localparam int MEM_WSTRB_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } store_size_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] val;
    store_size_t size;
  } sq_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } sq_state_t;

endpackage

// File: rtl/store_strb_gen.sv
// Lane replication and byte-strobe generation for word-aligned memory writes.
module store_strb_gen
  import turtle_mem_pkg::*;
(
  input  logic [1:0]             offset,
  input  store_size_t            size,
  input  logic [31:0]            val,
  output logic [31:0]            wdata,
  output logic [MEM_WSTRB_W-1:0] wstrb
);

  always_comb begin
    wdata = val;
    wstrb = 4'b1111;
    case (size)
      SZ_BYTE: begin
        wdata = {4{val[7:0]}};
        wstrb = 4'b0001 << offset;
      end
      SZ_HALF: begin
        // halfword lanes are selected by addr[1] alone
        wdata = {2{val[15:0]}};
        wstrb = 4'b0011 << {offset[1], 1'b0};
      end
      default: begin
        wdata = val;
        wstrb = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/store_queue.sv
// Committed-store buffer draining to the data-memory write port over req/ack.
// Optional load-address hazard compare is enabled with STORE_QUEUE_FWD_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no request outstanding; loads head into mem_* when count>0
// ST_REQ  | mem_req held with stable mem_*; pops head on mem_ack
module store_queue
  import turtle_mem_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            store_addr,
  input  logic [31:0]            store_val,
  input  logic [1:0]             store_size,
  input  logic                   store_valid,
  output logic                   storefifo_full,
  output logic                   storefifo_empty,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [MEM_WSTRB_W-1:0] mem_wstrb,
  output logic                   mem_req,
`ifdef STORE_QUEUE_FWD_EN
  input  logic [31:0]            load_chk_addr,
  output logic                   load_hazard,
`endif
  input  logic                   mem_ack,
  output logic                   size_err
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

  sq_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  sq_state_t        state;

  logic             push;
  logic             pop;
  logic [PTR_W-1:0] head_idx;
  sq_entry_t        head;
  logic [31:0]      head_wdata;
  logic [3:0]       head_wstrb;

  assign pop  = (state == ST_REQ) && mem_ack;
  // full is registered, so a push landing on a popping cycle is still accepted
  assign push = store_valid && (store_size != SZ_RSVD) && ((count != CNT_FULL) || pop);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  // in ST_REQ the entry being presented is at rd_ptr, so the next one is staged
  assign head_idx = (state == ST_REQ) ? rd_ptr + 1'b1 : rd_ptr;
  assign head     = entries[head_idx];

  store_strb_gen u_strb_gen (
    .offset (head.addr[1:0]),
    .size   (head.size),
    .val    (head.val),
    .wdata  (head_wdata),
    .wstrb  (head_wstrb)
  );

  always_ff @(posedge clk) begin
    if (push)
      entries[wr_ptr] <= '{addr: store_addr, val: store_val, size: store_size_t'(store_size)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      state          <= ST_IDLE;
      storefifo_full <= 1'b0;
      mem_req        <= 1'b0;
      size_err       <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wstrb      <= '0;
    end else begin
      size_err       <= store_valid && (store_size == SZ_RSVD);
      count          <= count_next;
      storefifo_full <= (count_next == CNT_FULL);
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      case (state)
        ST_IDLE: begin
          if (count != '0) begin
            mem_addr  <= {head.addr[31:2], 2'b00};
            mem_wdata <= head_wdata;
            mem_wstrb <= head_wstrb;
            mem_req   <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            if (count > CNT_ONE) begin
              mem_addr  <= {head.addr[31:2], 2'b00};
              mem_wdata <= head_wdata;
              mem_wstrb <= head_wstrb;
            end else begin
              mem_req <= 1'b0;
              state   <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign storefifo_empty = (count == '0) && (state == ST_IDLE);

`ifdef STORE_QUEUE_FWD_EN
  logic [PTR_W-1:0] slot_off;
  logic             unused_chk_lsb;

  assign unused_chk_lsb = ^load_chk_addr[1:0];

  // every counted slot is live, including the head that is currently in flight
  always_comb begin
    load_hazard = 1'b0;
    slot_off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PTR_W'(i) - rd_ptr;
      if (({1'b0, slot_off} < count) && (entries[i].addr[31:2] == load_chk_addr[31:2]))
        load_hazard = 1'b1;
    end
  end
`endif

  assert property (@(posedge clk) disable iff (reset) !(store_valid && storefifo_full && !pop))
    else $warning("store_queue: store_valid while full, store dropped");

endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Buffers committed stores from the store execute unit and drains them, one at a time, to the data-memory write port over a req/ack handshake.
- Produces the `storefifo_full` back-pressure signal consumed by the store execute unit.
- Owns lane replication and byte-strobe generation, so memory sees only word-aligned accesses.
- Sits between execute-stage store issue and the data-memory/bus interface.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- store_addr  input  32  byte address of the incoming store.
- store_val  input  32  store data, right-justified.
- store_size  input  2  0=byte, 1=half, 2=word, 3=reserved.
- store_valid  input  1  push strobe for the incoming store.
- storefifo_full  output  1  queue full; upstream must not assert store_valid.
- storefifo_empty  output  1  no entries queued and no request outstanding.
- mem_addr  output  32  word address, {head_addr[31:2], 2'b00}.
- mem_wdata  output  32  lane-replicated write data.
- mem_wstrb  output  4  byte enables.
- mem_req  output  1  write request, held until acknowledged.
- mem_ack  input  1  memory accepted the current request.
- size_err  output  1  one-cycle pulse when a reserved-size store is dropped.

Behaviour:
- Reset values:
  - count=0, read/write pointers=0, state=IDLE.
  - storefifo_full=0, storefifo_empty=1, mem_req=0, size_err=0.
  - mem_addr, mem_wdata and mem_wstrb are 0.
- Storage: circular buffer of {addr, val, size}; pointers wrap modulo DEPTH; count is PTR_W+1 bits wide.
- Push:
  - Occurs when store_valid=1 and count<DEPTH; the entry is written at the clock edge.
  - store_valid while full is ignored (simulation assertion fires); state is unchanged.
  - size=3: not enqueued; size_err pulses the next cycle.
- Flags: storefifo_full = (count==DEPTH), registered. storefifo_empty = (count==0 && state==IDLE).
- FSM states:
  - IDLE:
    - If count>0, load the mem_* registers from the head entry and go to REQ.
    - mem_req rises the cycle after the entry's push. Minimum push-to-req latency is 1 cycle.
  - REQ:
    - mem_req=1; mem_addr/wdata/wstrb are stable and must not change until ack.
    - On mem_ack=1: pop the head (rd_ptr++, count--).
    - If entries remain (excluding the popped one), load the next head and stay in REQ. Back-to-back requests occur with no bubble.
    - Otherwise drop mem_req and go to IDLE.
- mem_ack outside REQ is ignored.
- Simultaneous push and pop: count is unchanged. A pushed entry is never lost, including at full→pop+push (allowed because full is registered from the previous count).
- Lane/strobe rules, where o=addr[1:0]:
  - byte: wdata={4{val[7:0]}}, wstrb=4'b0001<<o.
  - half: wdata={2{val[15:0]}}, wstrb=4'b0011<<{o[1],1'b0}. o[0] is ignored.
  - word: wdata=val, wstrb=4'b1111. o is ignored.
- Misalignment is checked upstream and is not re-checked here.
- Pipeline flush has no port: queued stores are architecturally committed and always drain.
- Reset mid-REQ: mem_req drops the next cycle and all entries are discarded. The memory side must tolerate the abandoned request.

Optional Feature:
- Macro: STORE_QUEUE_FWD_EN.
- Defined:
  - Adds input load_chk_addr[31:0] and output load_hazard (combinational).
  - load_hazard=1 when any valid entry, or the in-flight head, has addr[31:2]==load_chk_addr[31:2].
  - The load unit stalls while load_hazard is 1.
- Undefined: the ports are absent, with no compare logic; the load unit must wait for storefifo_empty before loads.

Decomposition:
- Package turtle_mem_pkg:
  - store_size_t enum {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD}.
  - sq_entry_t struct {addr, val, size}.
  - MEM_WSTRB_W=4.
- Sub-module store_strb_gen: combinational size/offset/val → wdata/wstrb, reused later by the load-align path.

Test Plan:
- Reset, then push byte addr=0x1003, val=0xAB → next cycle:
  - mem_req=1, mem_addr=0x1000, mem_wdata=0xABABABAB, mem_wstrb=4'b1000.
  - ack → mem_req=0, storefifo_empty=1.
- Push 4 words with mem_ack=0 → storefifo_full=1 after the 4th.
  - 5th store_valid is ignored and the assertion fires.
  - Hold ack high → 4 consecutive req cycles in order, no bubbles.
- Full queue; assert mem_ack and a push in the same cycle → count stays 4; the new entry drains last with correct data.
- Push half addr=0x2002, val=0x1234_5678 → wdata=0x56785678, wstrb=4'b1100.
  - Push size=3 → not enqueued, size_err pulses 1 cycle.
- Reset asserted while in REQ with 3 entries queued → next cycle: mem_req=0, storefifo_empty=1, storefifo_full=0.
- STORE_QUEUE_FWD_EN: queue word at 0x3004, load_chk_addr=0x3006 → load_hazard=1.
  - load_chk_addr=0x3008 → load_hazard=0.
  - After ack → load_hazard=0.
